noise_envelope_shaper: RTL and testbench

Consumer end of the noise_shifters interface. It samples one noise bit (shell or explosion LFSR output) on each clk_12KHz_en tick and turns it into a signed audio sample with a triggered hold-then-decay amplitude envelope. One instance serves the shell sound and one serves the explosion sound; both feed the sound mixer.

---
 rtl/noise_env_pkg.sv | 18 +
 rtl/tick_divider.sv | 36 +++
 rtl/noise_envelope_shaper.sv | 113 +++++++++++
 tb/tb_noise_envelope_shaper.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/noise_env_pkg.sv
// Shared types and helpers for the noise envelope shaper.
package noise_env_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DECAY
    } state_e;

    function automatic int env_full(input logic loud, input int env_w);
        return loud ? (1 << env_w) - 1 : (1 << (env_w - 1)) - 1;
    endfunction

    function automatic int decay_step(input int env, input int shift);
        return (env >> shift) | 1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Tick counter with synchronous clear and a terminal-count pulse.
module tick_divider #(
    parameter int TERM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int W = $clog2(TERM + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o = en_i && (cnt_q == W'(TERM - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/noise_envelope_shaper.sv
// Turns a noise bit into a signed sample with a hold-then-decay envelope.
module noise_envelope_shaper
    import noise_env_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int ENV_W       = 8,
    parameter int HOLD_TICKS  = 96,
    parameter int DECAY_DIV   = 48,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_12KHz_en,
    input  logic                sound_enable,
    input  logic                noise,
    input  logic                trigger,
    input  logic                loud,
    output logic [SAMPLE_W-1:0] sample,
    output logic                busy
);

    localparam int SH = SAMPLE_W - ENV_W - 1;

    state_e             state_q;
    logic [ENV_W-1:0]   env_q;
    logic [ENV_W-1:0]   env_dec_d;
    logic [ENV_W-1:0]   step_d;
    logic [SAMPLE_W-1:0] mag_d;
    logic               trig_q;
    logic               start;
    logic               hold_tc;
    logic               div_tc;
    logic               cnt_clr;

    assign start   = trigger && !trig_q && sound_enable;
    assign cnt_clr = start || !sound_enable;

    tick_divider #(.TERM(HOLD_TICKS)) u_hold (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (clk_12KHz_en && (state_q == HOLD)),
        .tc_o  (hold_tc)
    );

    tick_divider #(.TERM(DECAY_DIV)) u_div (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr || hold_tc),
        .en_i  (clk_12KHz_en && (state_q == DECAY)),
        .tc_o  (div_tc)
    );

    always_comb begin
        step_d    = ENV_W'(decay_step(32'(env_q), DECAY_SHIFT));
        env_dec_d = (env_q > step_d) ? env_q - step_d : '0;
        mag_d     = SAMPLE_W'(env_q) << SH;
    end

    // Disable outranks start, and start outranks any hold/decay advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            env_q   <= '0;
            sample  <= '0;
            busy    <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            trig_q <= trigger;
            if (!sound_enable) begin
                state_q <= IDLE;
                env_q   <= '0;
                sample  <= '0;
                busy    <= 1'b0;
            end else begin
                if (clk_12KHz_en) begin
                    sample <= noise ? mag_d : -mag_d;
                end
                if (start) begin
                    env_q   <= ENV_W'(env_full(loud, ENV_W));
                    state_q <= HOLD;
                    busy    <= 1'b1;
                end else begin
                    unique case (state_q)
                        IDLE: begin
                            env_q <= '0;
                        end
                        HOLD: begin
                            if (hold_tc) begin
                                state_q <= DECAY;
                            end
                        end
                        DECAY: begin
                            if (div_tc) begin
                                env_q <= env_dec_d;
                                if (env_dec_d == '0) begin
                                    state_q <= IDLE;
                                    busy    <= 1'b0;
                                end
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            env_q   <= '0;
                            busy    <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_noise_envelope_shaper.sv
// Directed bench for noise_envelope_shaper with a short hold and decay divider.
module tb_noise_envelope_shaper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_12KHz_en = 1'b0;
    logic        sound_enable = 1'b0;
    logic        noise = 1'b0;
    logic        trigger = 1'b0;
    logic        loud = 1'b0;
    logic [15:0] sample;
    logic        busy;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int env_m;
    int divc;
    int stp;

    always #5 clk = ~clk;

    noise_envelope_shaper #(
        .SAMPLE_W    (16),
        .ENV_W       (8),
        .HOLD_TICKS  (2),
        .DECAY_DIV   (4),
        .DECAY_SHIFT (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_12KHz_en (clk_12KHz_en),
        .sound_enable (sound_enable),
        .noise        (noise),
        .trigger      (trigger),
        .loud         (loud),
        .sample       (sample),
        .busy         (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        clk_12KHz_en = 1'b1;
        @(negedge clk);
        clk_12KHz_en = 1'b0;
    endtask

    task automatic trig_pulse(input logic l);
        @(negedge clk);
        trigger = 1'b1;
        loud = l;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    function automatic int smp();
        return int'($signed(sample));
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("reset_sample", smp(), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        sound_enable = 1'b1;

        for (int i = 0; i < 50; i++) begin
            noise = 1'($urandom_range(0, 1));
            tick();
            check("idle_sample", smp(), 0);
            check("idle_busy", int'(busy), 0);
        end

        // Loud trigger: hold 2 ticks, decay every 4 ticks.
        noise = 1'b1;
        trig_pulse(1'b1);
        check("start_busy", int'(busy), 1);
        tick();
        check("loud_pos", smp(), 32640);
        noise = 1'b0;
        tick();
        check("loud_neg", smp(), -32640);
        repeat (4) tick();
        check("pre_decay", smp(), -32640);
        noise = 1'b1;
        tick();
        check("env224", smp(), 28672);
        repeat (3) tick();
        noise = 1'b0;
        tick();
        check("env195", smp(), -24960);

        // Quiet retrigger mid-decay, then run to completion.
        noise = 1'b1;
        trig_pulse(1'b0);
        tick();
        check("quiet_pos", smp(), 16256);
        noise = 1'b0;
        tick();
        check("quiet_neg", smp(), -16256);
        env_m = 127;
        divc = 0;
        for (int i = 0; i < 400; i++) begin
            noise = 1'b1;
            tick();
            check("decay_sample", smp(), env_m << 7);
            if (divc == 3) begin
                divc = 0;
                stp = (env_m >> 3) | 1;
                env_m = (env_m > stp) ? env_m - stp : 0;
            end else begin
                divc++;
            end
            check("decay_busy", int'(busy), int'(env_m != 0));
            if (env_m == 0) break;
        end
        check("decay_done", env_m, 0);
        repeat (3) begin
            noise = 1'b1;
            tick();
            check("after_sample", smp(), 0);
            check("after_busy", int'(busy), 0);
        end

        // Retrigger on a clk that is also a decay-terminal tick.
        trig_pulse(1'b1);
        repeat (6) tick();
        repeat (3) tick();
        @(negedge clk);
        trigger = 1'b1;
        clk_12KHz_en = 1'b1;
        noise = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        clk_12KHz_en = 1'b0;
        check("retrig_old_env", smp(), 28672);
        check("retrig_busy", int'(busy), 1);
        tick();
        check("retrig_full", smp(), 32640);
        repeat (5) tick();
        check("retrig_hold", smp(), 32640);
        tick();
        check("retrig_decay", smp(), 28672);

        // Disable mid-hold with trigger held high.
        @(negedge clk);
        trigger = 1'b1;
        loud = 1'b1;
        @(negedge clk);
        tick();
        check("hold_sample", smp(), 32640);
        @(negedge clk);
        sound_enable = 1'b0;
        @(negedge clk);
        check("dis_sample", smp(), 0);
        check("dis_busy", int'(busy), 0);
        sound_enable = 1'b1;
        repeat (3) tick();
        check("reen_sample", smp(), 0);
        check("reen_busy", int'(busy), 0);
        @(negedge clk);
        trigger = 1'b0;
        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        check("fresh_busy", int'(busy), 1);
        tick();
        check("fresh_sample", smp(), 32640);
        trigger = 1'b0;

        // Reset in the middle of a sound.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_sample", smp(), 0);
        check("rst_mid_busy", int'(busy), 0);
        tick();
        check("rst_mid_after", smp(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
